// File: rtl/count_pkg.sv
// -----------------------------------------------------------------------------
// count_pkg
// Shared types for the counter-sequence monitor: the event-type encoding,
// the 13-bit packed event record and the default event FIFO depth.
//
// Record layout (MSB..LSB):
//   [12:11] typ   - EVT_WRAP (01) or EVT_SKIP (10)
//   [10:8]  cnt   - count_in value that produced the event
//   [7:0]   tally - wrap tally after the event
// -----------------------------------------------------------------------------
package count_pkg;

   localparam int COUNT_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      EVT_NONE = 2'b00,
      EVT_WRAP = 2'b01,
      EVT_SKIP = 2'b10
   } evt_type_e;

   typedef struct packed {
      evt_type_e   typ;
      logic [2:0]  cnt;
      logic [7:0]  tally;
   } evt_rec_t;

   function automatic evt_rec_t make_rec(input evt_type_e  t,
                                         input logic [2:0] c,
                                         input logic [7:0] tl);
      evt_rec_t r;
      r.typ   = t;
      r.cnt   = c;
      r.tally = tl;
      return r;
   endfunction

endpackage

// File: rtl/event_fifo.sv
// -----------------------------------------------------------------------------
// event_fifo
// Synchronous first-in first-out buffer for event records. No fall-through:
// a pushed entry becomes visible on o_head after the edge that wrote it.
// Pointers carry one extra bit above the address so full and empty are
// distinguishable when the addresses match.
//
// Ports:
//   clk     - clock
//   rst     - synchronous active-high flush
//   i_push  - write i_data at this edge (dropped when full without a pop)
//   i_pop   - retire the head entry at this edge (ignored when empty)
//   i_data  - record to write
//   o_full  - DEPTH entries held
//   o_empty - no entries held
//   o_head  - oldest entry, zero when empty
// -----------------------------------------------------------------------------
module event_fifo #(
   parameter int  DEPTH = 4,
   parameter type rec_t = logic [12:0]
) (
   input  logic clk,
   input  logic rst,
   input  logic i_push,
   input  logic i_pop,
   input  rec_t i_data,
   output logic o_full,
   output logic o_empty,
   output rec_t o_head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   rec_t        r_mem [DEPTH];

   logic w_push_ok;
   logic w_pop_ok;

   always_comb begin
      o_empty   = (r_wr_ptr == r_rd_ptr);
      o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
      w_pop_ok  = i_pop & ~o_empty;
      // A same-edge pop frees the slot the write lands in, so full is no block.
      w_push_ok = i_push & (~o_full | w_pop_ok);
      o_head    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // Storage holds no control state and needs no reset.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/count_monitor.sv
// -----------------------------------------------------------------------------
// count_monitor
// Watches samples of an upstream free-running 3-bit counter. After one priming
// cycle it checks every sample against the previous one plus one (mod 8):
// a 7->0 step is a WRAP (tally incremented), any other non-increment is a SKIP.
// Events are queued in event_fifo for a valid/ready consumer; events that find
// the queue full are dropped and latch a sticky overflow flag.
//
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset
//   count_in   - counter sample, one per cycle
//   evt_valid  - head event present on evt_data
//   evt_ready  - consumer accepts head event
//   evt_data   - {type[1:0], count[2:0], tally[7:0]}
//   wrap_count - running wrap tally
//   overflow   - sticky: an event was dropped since reset
// -----------------------------------------------------------------------------
module count_monitor
   import count_pkg::*;
#(
   parameter int DEPTH = COUNT_FIFO_DEPTH,
   parameter int WRAPW = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       count_in,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [12:0]      evt_data,
   output logic [WRAPW-1:0] wrap_count,
   output logic             overflow
);

   typedef enum logic {ST_PRIME = 1'b0, ST_RUN = 1'b1} state_e;

   localparam logic [WRAPW-1:0] WRAP_ONE = WRAPW'(1);

   state_e           r_state;
   logic [2:0]       r_prev;
   logic [WRAPW-1:0] r_wrap;
   logic             r_ovf;

   logic             w_run;
   logic [2:0]       w_expect;
   logic             w_is_wrap;
   logic             w_is_skip;
   logic [WRAPW-1:0] w_wrap_next;
   logic             w_push;
   logic             w_pop;
   logic             w_drop;
   logic             w_full;
   logic             w_empty;
   evt_rec_t         w_rec;
   evt_rec_t         w_head;

   always_comb begin
      w_run       = (r_state == ST_RUN) & ~rst;
      w_expect    = r_prev + 3'd1;
      // The 7->0 step is the one legal increment that counts as an event.
      w_is_wrap   = w_run && (r_prev == 3'd7) && (count_in == 3'd0);
      w_is_skip   = w_run && (count_in != w_expect);
      w_wrap_next = r_wrap + WRAP_ONE;
      w_push      = w_is_wrap | w_is_skip;
      w_rec       = make_rec(EVT_NONE, count_in, 8'(r_wrap));
      if (w_is_wrap) w_rec = make_rec(EVT_WRAP, count_in, 8'(w_wrap_next));
      else if (w_is_skip) w_rec = make_rec(EVT_SKIP, count_in, 8'(r_wrap));
      evt_valid   = ~w_empty & ~rst;
      evt_data    = rst ? 13'd0 : w_head;
      w_pop       = evt_valid & evt_ready;
      w_drop      = w_push & w_full & ~w_pop;
      wrap_count  = r_wrap;
      overflow    = r_ovf;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_PRIME;
         r_prev  <= 3'd0;
         r_wrap  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_prev <= count_in;
         case (r_state)
            ST_PRIME: r_state <= ST_RUN;
            ST_RUN: begin
               if (w_is_wrap) r_wrap <= w_wrap_next;
            end
            default: r_state <= ST_PRIME;
         endcase
         if (w_drop) r_ovf <= 1'b1;
      end
   end

   event_fifo #(
      .DEPTH (DEPTH),
      .rec_t (evt_rec_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_rec),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

endmodule

// File: tb/tb_count_monitor.sv
module tb_count_monitor;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic [2:0]  count_in;
   logic        evt_valid;
   logic        evt_ready;
   logic [12:0] evt_data;
   logic [7:0]  wrap_count;
   logic        overflow;

   count_monitor #(.DEPTH(DEPTH), .WRAPW(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .count_in   (count_in),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_data   (evt_data),
      .wrap_count (wrap_count),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: queue of records plus a few scalars.
   logic [12:0] m_q [$];
   int          m_wrap = 0;
   bit          m_ovf  = 0;
   bit          m_run  = 0;
   int          m_prev = 0;
   bit          m_last_rst = 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input int c, input bit r, input bit rs);
      bit          ev;
      logic [1:0]  typ;
      bit          pop;
      logic [12:0] rec;
      m_last_rst = rs;
      if (rs) begin
         m_q.delete();
         m_wrap = 0;
         m_ovf  = 0;
         m_run  = 0;
         m_prev = 0;
         return;
      end
      ev  = 0;
      typ = 2'b00;
      pop = r && (m_q.size() > 0);
      if (m_run) begin
         if (c != (m_prev + 1) % 8) begin
            ev = 1; typ = 2'b10;
         end else if (c == 0) begin
            m_wrap = (m_wrap + 1) % 256;
            ev = 1; typ = 2'b01;
         end
      end
      if (pop) void'(m_q.pop_front());
      if (ev) begin
         rec = {typ, 3'(c), 8'(m_wrap)};
         if (m_q.size() < DEPTH) m_q.push_back(rec);
         else m_ovf = 1;
      end
      m_prev = c;
      m_run  = 1;
   endtask

   task automatic compare_model();
      check("valid", 32'(evt_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) check("data", 32'(evt_data), 32'(m_q[0]));
      else if (m_last_rst) check("data_rst", 32'(evt_data), 32'd0);
      check("wrap", 32'(wrap_count), 32'(m_wrap));
      check("ovf", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic step(input int c, input bit r, input bit rs);
      @(negedge clk);
      count_in  = 3'(c);
      evt_ready = r;
      rst       = rs;
      model_edge(c, r, rs);
      @(posedge clk);
      #1;
      compare_model();
   endtask

   typedef struct {
      int          cnt;
      bit          rdy;
      bit          rs;
      bit          ev;
      logic [12:0] ed;
      logic [7:0]  ew;
      bit          eo;
   } vec_t;

   vec_t tbl [$];

   task automatic add(input int c, input bit r, input bit rs, input bit ev,
                      input logic [12:0] ed, input logic [7:0] ew, input bit eo);
      vec_t v;
      v.cnt = c; v.rdy = r; v.rs = rs; v.ev = ev; v.ed = ed; v.ew = ew; v.eo = eo;
      tbl.push_back(v);
   endtask

   task automatic prime_skips(input bit r);
      // Prime with 0, then four SKIPs carrying counts 0,2,4,6.
      step(0, 0, 1);
      step(0, r, 0);
      step(0, r, 0);
      step(2, r, 0);
      step(4, r, 0);
      step(6, r, 0);
   endtask

   initial begin
      int pops;
      int c;
      rst = 1'b1; count_in = 3'd0; evt_ready = 1'b0;
      step(0, 0, 1);
      check("reset_valid", 32'(evt_valid), 32'd0);
      check("reset_wrap", 32'(wrap_count), 32'd0);
      check("reset_ovf", 32'(overflow), 32'd0);

      // Clean sequence with one wrap, then a skip after a fresh reset.
      add(0, 1, 1, 0, 13'h000, 8'd0, 0);
      add(0, 1, 0, 0, 13'h000, 8'd0, 0);
      for (int i = 1; i < 8; i++) add(i, 1, 0, 0, 13'h000, 8'd0, 0);
      add(0, 1, 0, 1, 13'b01_000_00000001, 8'd1, 0);
      add(1, 1, 0, 0, 13'h000, 8'd1, 0);
      add(3, 1, 1, 0, 13'h000, 8'd0, 0);
      add(3, 1, 0, 0, 13'h000, 8'd0, 0);
      add(4, 1, 0, 0, 13'h000, 8'd0, 0);
      add(6, 1, 0, 1, 13'b10_110_00000000, 8'd0, 0);
      add(7, 1, 0, 0, 13'h000, 8'd0, 0);
      foreach (tbl[i]) begin
         step(tbl[i].cnt, tbl[i].rdy, tbl[i].rs);
         check($sformatf("tbl%0d_valid", i), 32'(evt_valid), 32'(tbl[i].ev));
         if (tbl[i].ev || tbl[i].rs) check($sformatf("tbl%0d_data", i), 32'(evt_data), 32'(tbl[i].ed));
         check($sformatf("tbl%0d_wrap", i), 32'(wrap_count), 32'(tbl[i].ew));
         check($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].eo));
      end

      // Overflow: six SKIPs with the consumer stalled.
      prime_skips(0);
      check("full4_ovf", 32'(overflow), 32'd0);
      check("full4_head", 32'(evt_data), 32'(13'h1000));
      step(0, 0, 0);
      check("drop5_ovf", 32'(overflow), 32'd1);
      step(2, 0, 0);
      check("drop6_head", 32'(evt_data), 32'(13'h1000));
      step(3, 1, 0); check("drain1", 32'(evt_data), 32'(13'h1200));
      step(4, 1, 0); check("drain2", 32'(evt_data), 32'(13'h1400));
      step(5, 1, 0); check("drain3", 32'(evt_data), 32'(13'h1600));
      step(6, 1, 0); check("drain4_empty", 32'(evt_valid), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // Push and pop on a full queue in the same cycle.
      prime_skips(0);
      step(0, 1, 0);
      check("pp_ovf", 32'(overflow), 32'd0);
      check("pp_head", 32'(evt_data), 32'(13'h1200));
      pops = 0;
      c = 1;
      for (int i = 0; i < 8 && evt_valid; i++) begin
         step(c, 1, 0);
         c = (c + 1) % 8;
         pops++;
      end
      check("pp_occupancy", 32'(pops), 32'd4);

      // 256 clean wraps bring the tally back to zero.
      step(0, 1, 1);
      step(0, 1, 0);
      for (int w = 1; w <= 256; w++) begin
         for (int i = 1; i < 8; i++) step(i, 1, 0);
         step(0, 1, 0);
         if (w == 255) check("wrap255", 32'(wrap_count), 32'd255);
         if (w == 256) begin
            check("wrap256_cnt", 32'(wrap_count), 32'd0);
            check("wrap256_rec", 32'(evt_data), 32'(13'b01_000_00000000));
         end
      end

      // Reset with entries queued and a nonzero tally.
      step(0, 0, 1);
      step(6, 0, 0);
      step(7, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      step(5, 0, 0);
      check("pre_rst_wrap", 32'(wrap_count), 32'd1);
      step(5, 0, 1);
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_wrap", 32'(wrap_count), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_data", 32'(evt_data), 32'd0);
      step(2, 1, 0);
      check("prime_no_evt", 32'(evt_valid), 32'd0);
      step(3, 1, 0);
      check("after_prime", 32'(evt_valid), 32'd0);

      // Random traffic against the model.
      c = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < 65) c = (c + 1) % 8;
         else c = int'($urandom_range(7));
         step(c, bit'($urandom_range(99) < 50), bit'($urandom_range(199) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter DEPTH, default 4, event FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter WRAPW, default 8, width of the wrap tally.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 count_in  input  3  sample of the upstream free-running 3-bit counter, one new value per cycle.
REQ-006 evt_valid  output  1  head FIFO entry is presented on evt_data.
REQ-007 evt_ready  input  1  consumer accepts head entry when evt_valid and evt_ready are both high.
REQ-008 evt_data  output  13  event record: [12:11] type (01 WRAP, 10 SKIP), [10:8] count_in value, [7:0] wrap tally after the event.
REQ-009 wrap_count  output  WRAPW  running wrap tally.
REQ-010 overflow  output  1  sticky flag: at least one event was dropped.

Function
REQ-011 The block SHALL implement a two-state machine, PRIME and RUN; reset enters PRIME.
REQ-012 In PRIME the block SHALL capture count_in into prev, generate no event, and move to RUN next cycle.
REQ-013 In RUN each cycle SHALL compare count_in with (prev+1) mod 8, then load prev with count_in.
REQ-014 prev==7 and count_in==0 SHALL generate a WRAP event and increment wrap_count modulo 2^WRAPW (255->0 with default WRAPW).
REQ-015 count_in != (prev+1) mod 8, including count_in==prev, SHALL generate a SKIP event; wrap_count SHALL remain unchanged.
REQ-016 At most one event per cycle; WRAP and SKIP are mutually exclusive by definition.
REQ-017 An event detected from count_in at edge N SHALL be written at edge N; evt_valid SHALL be high after edge N if the FIFO was empty (one-cycle latency).
REQ-018 The wrap tally field in a WRAP record SHALL hold the incremented value.
REQ-019 The FIFO SHALL be strict first-in first-out with no fall-through; evt_valid = not empty.
REQ-020 evt_data and evt_valid SHALL stay stable while evt_valid is high and evt_ready is low.
REQ-021 evt_ready while the FIFO is empty SHALL have no effect.
REQ-022 Simultaneous push and pop SHALL both take effect, occupancy unchanged, including when full.
REQ-023 A push while full without a same-cycle pop SHALL be dropped and SHALL set overflow; FIFO contents unchanged.
REQ-024 overflow SHALL clear only on rst.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH with one extra bit distinguishing full from empty.

Reset
REQ-026 rst high at any edge SHALL, at that edge, flush the FIFO and clear wrap_count and overflow to 0 and the state to PRIME, discarding any in-progress event.
REQ-027 While rst is high, evt_valid=0, wrap_count=0, overflow=0 and no event SHALL be generated; evt_data SHALL be 0.
REQ-028 The first cycle after rst falls SHALL be PRIME.

Structure
REQ-029 A shared package count_pkg SHALL hold the event-type enum (EVT_WRAP=2'b01, EVT_SKIP=2'b10), the 13-bit packed event record typedef and the default DEPTH constant.
REQ-030 The FIFO SHALL be a separate sub-module, event_fifo, parameterised by DEPTH and record type, exposing push, pop, full, empty and head data.
REQ-031 count_monitor SHALL contain only the PRIME/RUN machine, prev register, comparator, wrap tally and overflow flag.

Verification
REQ-032 Reset, then count_in 0,1,...,7,0 with evt_ready=1 -> exactly one WRAP, evt_data=13'b01_000_00000001, one cycle after count_in=0; wrap_count=1.
REQ-033 count_in 3,4,6 in RUN -> one SKIP record type 10, count 6, tally 0; no event for 3->4.
REQ-034 evt_ready=0, force 6 SKIPs (DEPTH=4) -> 4 entries held, overflow=1 after the 5th; drain yields the first four in order.
REQ-035 FIFO full, push SKIP with evt_ready=1 in the same cycle -> head popped, new entry accepted, overflow stays 0, occupancy 4.
REQ-036 Run 256 clean wraps -> wrap_count returns to 0; 256th WRAP record carries tally 0.
REQ-037 Assert rst for one cycle with 3 entries queued -> evt_valid=0 next cycle, wrap_count=0, overflow=0; the cycle after rst falls is PRIME and generates no event regardless of count_in.
